// File: rtl/sfm_pkg.sv
// Shared softmax types: floating-point format descriptors, min/max mode,
// accumulator FSM states and fp constant helpers.
package sfm_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic {
        MIN = 1'b0,
        MAX = 1'b1
    } min_max_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } max_acc_state_e;

    localparam int unsigned FP_MAX_WIDTH = 64;

    function automatic int unsigned fp_exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned fp_man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
    endfunction

    // -inf for MAX, +inf for MIN, right-aligned in a 64-bit container.
    function automatic logic [FP_MAX_WIDTH-1:0] fp_minmax_identity(fp_format_e fmt, min_max_mode_t mode);
        logic [FP_MAX_WIDTH-1:0] res;
        int unsigned             e;
        int unsigned             m;
        e   = fp_exp_bits(fmt);
        m   = fp_man_bits(fmt);
        res = {FP_MAX_WIDTH{1'b0}};
        for (int unsigned i = 0; i < FP_MAX_WIDTH; i++) begin
            if (i >= m && i < m + e) begin
                res[i] = 1'b1;
            end else if (i == m + e) begin
                res[i] = (mode == MAX);
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    function automatic logic [FP_MAX_WIDTH-1:0] fp_canonical_nan(fp_format_e fmt);
        logic [FP_MAX_WIDTH-1:0] res;
        int unsigned             e;
        int unsigned             m;
        e   = fp_exp_bits(fmt);
        m   = fp_man_bits(fmt);
        res = {FP_MAX_WIDTH{1'b0}};
        for (int unsigned i = 0; i < FP_MAX_WIDTH; i++) begin
            if ((i >= m && i < m + e) || (i + 1 == m)) begin
                res[i] = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sfm_fp_minmax_rec.sv
// N-operand floating-point min/max with per-operand strobes; NaN operands are
// ignored unless nothing else is left, in which case the canonical qNaN results.
module sfm_fp_minmax_rec
    import sfm_pkg::*;
#(
    parameter fp_format_e    FPFORMAT = FP16ALT,
    parameter int unsigned   N_INP    = 2,
    localparam int unsigned  WIDTH    = fp_width(FPFORMAT)
) (
    input  logic [N_INP-1:0][WIDTH-1:0] operands_i,
    input  logic [N_INP-1:0]            strb_i,
    input  min_max_mode_t               mode_i,
    output logic [WIDTH-1:0]            result_o
);

    localparam int unsigned              EXP_BITS  = fp_exp_bits(FPFORMAT);
    localparam int unsigned              MAN_BITS  = fp_man_bits(FPFORMAT);
    localparam logic [FP_MAX_WIDTH-1:0]  QNAN_FULL = fp_canonical_nan(FPFORMAT);
    localparam logic [WIDTH-1:0]         QNAN      = QNAN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] res_s;
    logic             have_s;

    function automatic logic is_nan(logic [WIDTH-1:0] x);
        return (&x[WIDTH-2 -: EXP_BITS]) && (|x[MAN_BITS-1:0]);
    endfunction

    // Total order on non-NaN values, so -0 sorts strictly below +0.
    function automatic logic less_than(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            return a[WIDTH-1];
        end else if (a[WIDTH-1]) begin
            return a[WIDTH-2:0] > b[WIDTH-2:0];
        end else begin
            return a[WIDTH-2:0] < b[WIDTH-2:0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] pick(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, min_max_mode_t mode);
        if (is_nan(a) && is_nan(b)) begin
            return QNAN;
        end else if (is_nan(a)) begin
            return b;
        end else if (is_nan(b)) begin
            return a;
        end else if (mode == MAX) begin
            return less_than(a, b) ? b : a;
        end else begin
            return less_than(b, a) ? b : a;
        end
    endfunction

    // Fold the strobed operands left to right.
    always_comb begin
        res_s  = QNAN;
        have_s = 1'b0;
        for (int i = 0; i < int'(N_INP); i++) begin
            res_s  = strb_i[i] ? (have_s ? pick(res_s, operands_i[i], mode_i) : operands_i[i]) : res_s;
            have_s = have_s | strb_i[i];
        end
        result_o = is_nan(res_s) ? QNAN : res_s;
    end

endmodule

// File: rtl/sfm_fp_max_acc.sv
// Row-wise running min/max accumulator: folds one reduced scalar per beat and
// reports the running value before and after each beat.
module sfm_fp_max_acc
    import sfm_pkg::*;
#(
    parameter fp_format_e   FPFORMAT  = FP16ALT,
    parameter int unsigned  CNT_WIDTH = 16,
    localparam int unsigned WIDTH     = fp_width(FPFORMAT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 strb_i,
    input  logic                 last_i,
    input  min_max_mode_t        mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     max_o,
    output logic [WIDTH-1:0]     prev_max_o,
    output logic                 changed_o,
    output logic                 last_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [FP_MAX_WIDTH-1:0] ID_MAX_FULL = fp_minmax_identity(FPFORMAT, MAX);
    localparam logic [WIDTH-1:0]        ID_MAX      = ID_MAX_FULL[WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_SAT     = {CNT_WIDTH{1'b1}};

    max_acc_state_e        state_q, state_d;
    min_max_mode_t         mode_q, mode_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  valid_q;
    logic [WIDTH-1:0]      max_q;
    logic [WIDTH-1:0]      prev_q;
    logic                  changed_q;
    logic                  last_q;
    logic [CNT_WIDTH-1:0]  cnt_out_q;

    logic                  ready_s;
    logic                  accept_s;
    min_max_mode_t         mode_eff_s;
    logic                  acc_live_s;
    logic [WIDTH-1:0]      fold_s;
    logic [WIDTH-1:0]      new_val_s;
    logic [CNT_WIDTH-1:0]  cnt_new_s;

    assign ready_s    = enable_i & ~clear_i & (~valid_q | ready_i);
    assign accept_s   = valid_i & ready_s;
    assign mode_eff_s = (state_q == IDLE) ? mode_i : mode_q;
    // Until the row has seen a real value the identity stays out of the fold,
    // so a NaN leading beat survives as the canonical qNaN.
    assign acc_live_s = (cnt_q != CNT_ZERO);
    assign new_val_s  = strb_i ? fold_s : acc_q;
    assign cnt_new_s  = (strb_i && (cnt_q != CNT_SAT)) ? (cnt_q + CNT_ONE) : cnt_q;

    sfm_fp_minmax_rec #(
        .FPFORMAT (FPFORMAT),
        .N_INP    (2)
    ) u_minmax (
        .operands_i ({acc_q, data_i}),
        .strb_i     ({acc_live_s, strb_i}),
        .mode_i     (mode_eff_s),
        .result_o   (fold_s)
    );

    // Next-state logic for the row FSM, accumulator and counter.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    mode_d  = mode_i;
                    state_d = last_i ? IDLE : ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (accept_s && last_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept_s && last_i) begin
            acc_d = ID_MAX;
            cnt_d = CNT_ZERO;
        end else if (accept_s) begin
            acc_d = new_val_s;
            cnt_d = cnt_new_s;
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Row state registers; clear_i aborts the row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= MAX;
            acc_q   <= ID_MAX;
            cnt_q   <= CNT_ZERO;
        end else if (clear_i) begin
            state_q <= IDLE;
            mode_q  <= MAX;
            acc_q   <= ID_MAX;
            cnt_q   <= CNT_ZERO;
        end else if (enable_i) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output beat register with valid/ready hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            max_q     <= {WIDTH{1'b0}};
            prev_q    <= {WIDTH{1'b0}};
            changed_q <= 1'b0;
            last_q    <= 1'b0;
            cnt_out_q <= CNT_ZERO;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
        end else if (enable_i) begin
            if (accept_s) begin
                valid_q   <= 1'b1;
                max_q     <= new_val_s;
                prev_q    <= acc_q;
                changed_q <= (new_val_s != acc_q);
                last_q    <= last_i;
                cnt_out_q <= cnt_new_s;
            end else if (ready_i) begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign ready_o    = ready_s;
    assign valid_o    = valid_q;
    assign max_o      = max_q;
    assign prev_max_o = prev_q;
    assign changed_o  = changed_q;
    assign last_o     = last_q;
    assign cnt_o      = cnt_out_q;

endmodule

// File: tb/tb_sfm_fp_max_acc.sv
// Randomized and directed bench for sfm_fp_max_acc against a row-level
// reference model of running min/max over FP16ALT values.
module tb_sfm_fp_max_acc;
    import sfm_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          enable_i;
    logic          valid_i;
    logic          ready_o;
    logic [15:0]   data_i;
    logic          strb_i;
    logic          last_i;
    min_max_mode_t mode_i;
    logic          valid_o;
    logic          ready_i;
    logic [15:0]   max_o;
    logic [15:0]   prev_max_o;
    logic          changed_o;
    logic          last_o;
    logic [15:0]   cnt_o;

    sfm_fp_max_acc #(.FPFORMAT(FP16ALT), .CNT_WIDTH(16)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .enable_i   (enable_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .strb_i     (strb_i),
        .last_i     (last_i),
        .mode_i     (mode_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .max_o      (max_o),
        .prev_max_o (prev_max_o),
        .changed_o  (changed_o),
        .last_o     (last_o),
        .cnt_o      (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] pv;
        logic        ch;
        logic        la;
        logic [15:0] cn;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            hold_cnt = 0;

    logic [15:0]   m_acc = 16'hFF80;
    bit            m_have = 1'b0;
    bit            m_in_row = 1'b0;
    int            m_cnt = 0;
    min_max_mode_t m_mode = MAX;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_nan16(logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    // Signed ordering key; -0 maps just below +0.
    function automatic int key(logic [15:0] x);
        return x[15] ? (-int'(x[14:0]) - 1) : int'(x[14:0]);
    endfunction

    function automatic logic [15:0] ref_pick(logic [15:0] a, logic [15:0] b, min_max_mode_t m);
        if (is_nan16(a) && is_nan16(b)) return 16'h7FC0;
        if (is_nan16(a)) return b;
        if (is_nan16(b)) return a;
        if (m == MAX) return (key(b) > key(a)) ? b : a;
        return (key(b) < key(a)) ? b : a;
    endfunction

    task automatic model_reset();
        m_acc    = 16'hFF80;
        m_have   = 1'b0;
        m_in_row = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model_accept(input logic [15:0] d, input logic s, input logic l, input min_max_mode_t m);
        exp_t e;
        if (!m_in_row) begin
            m_mode   = m;
            m_in_row = 1'b1;
        end
        e.pv = m_acc;
        if (s) begin
            if (m_cnt < 65535) m_cnt++;
            if (!m_have) m_acc = is_nan16(d) ? 16'h7FC0 : d;
            else         m_acc = ref_pick(m_acc, d, m_mode);
            m_have = 1'b1;
        end
        e.mx = m_acc;
        e.ch = (m_acc != e.pv);
        e.la = l;
        e.cn = 16'(m_cnt);
        exp_q.push_back(e);
        if (l) model_reset();
    endtask

    task automatic tick(input logic v, input logic [15:0] d, input logic s, input logic l,
                        input min_max_mode_t m, input logic en, input logic clr, output bit acc_o);
        bit exp_v;
        @(negedge clk_i);
        valid_i  = v;
        data_i   = d;
        strb_i   = s;
        last_i   = l;
        mode_i   = m;
        enable_i = en;
        clear_i  = clr;
        ready_i  = (hold_cnt > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (hold_cnt > 0) hold_cnt--;
        #1;
        exp_v = (exp_q.size() != 0);
        check_eq("valid_o", valid_o, exp_v);
        check_eq("ready_o", ready_o, en & ~clr & (~exp_v | ready_i));
        if (exp_v) begin
            check_eq("max_o", max_o, exp_q[0].mx);
            check_eq("prev_max_o", prev_max_o, exp_q[0].pv);
            check_eq("changed_o", changed_o, exp_q[0].ch);
            check_eq("last_o", last_o, exp_q[0].la);
            check_eq("cnt_o", cnt_o, exp_q[0].cn);
        end
        acc_o = v & en & ~clr & (~exp_v | ready_i);
        if (clr) begin
            exp_q.delete();
            model_reset();
        end else if (en && exp_v && ready_i) begin
            void'(exp_q.pop_front());
        end
        if (acc_o) model_accept(d, s, l, m);
    endtask

    task automatic send(input logic [15:0] d, input logic s, input logic l, input min_max_mode_t m);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 200) begin
            tick(1'b1, d, s, l, m, 1'b1, 1'b0, acc);
            n++;
        end
        check_eq("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic en);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b0, 1'b0, MAX, en, 1'b0, acc);
    endtask

    function automatic logic [15:0] rnd_data();
        case ($urandom_range(0, 9))
            0:       return 16'h7FC0;
            1:       return 16'hFF81;
            2:       return 16'h0000;
            3:       return 16'h8000;
            4:       return 16'h7F80;
            5:       return 16'hFF80;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0;
        data_i = 16'h0000; strb_i = 1'b0; last_i = 1'b0; mode_i = MAX; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("rst_valid_o", valid_o, 1'b0);
        check_eq("rst_max_o", max_o, 16'h0000);
        check_eq("rst_prev_max_o", prev_max_o, 16'h0000);
        check_eq("rst_changed_o", changed_o, 1'b0);
        check_eq("rst_last_o", last_o, 1'b0);
        check_eq("rst_cnt_o", cnt_o, 16'h0000);
        rst_ni = 1'b1;

        // Directed rows from the feature list.
        send(16'h3F80, 1'b1, 1'b0, MAX);
        send(16'h4000, 1'b1, 1'b0, MAX);
        send(16'hBF80, 1'b1, 1'b1, MAX);
        send(16'h3F80, 1'b1, 1'b0, MIN);
        send(16'hBF80, 1'b1, 1'b1, MIN);
        send(16'h3F80, 1'b1, 1'b1, MAX);
        send(16'h7FC0, 1'b1, 1'b0, MAX);
        send(16'h3F80, 1'b1, 1'b1, MAX);
        send(16'h7FC0, 1'b1, 1'b1, MAX);
        send(16'h8000, 1'b1, 1'b0, MAX);
        send(16'h0000, 1'b1, 1'b1, MAX);
        send(16'h1234, 1'b0, 1'b0, MAX);
        send(16'h5678, 1'b0, 1'b1, MAX);

        // Backpressure burst with beats queued behind it.
        send(16'h3F80, 1'b1, 1'b0, MAX);
        hold_cnt = 4;
        send(16'h4000, 1'b1, 1'b0, MAX);
        send(16'h4040, 1'b1, 1'b1, MAX);

        // Abort mid-row, then a fresh row.
        send(16'h4000, 1'b1, 1'b0, MAX);
        send(16'h4040, 1'b1, 1'b0, MAX);
        tick(1'b1, 16'h4080, 1'b1, 1'b0, MAX, 1'b1, 1'b1, acc);
        send(16'h3F80, 1'b1, 1'b1, MAX);

        // Stall mid-row.
        send(16'h3F80, 1'b1, 1'b0, MIN);
        for (int i = 0; i < 3; i++) tick(1'b1, 16'hBF80, 1'b1, 1'b0, MIN, 1'b0, 1'b0, acc);
        send(16'hBF80, 1'b1, 1'b0, MIN);
        send(16'h4000, 1'b1, 1'b1, MIN);

        // Randomized stream.
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3), $urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) hold_cnt = $urandom_range(1, 5);
            send(rnd_data(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) != 0) ? MAX : MIN);
            if ($urandom_range(0, 49) == 0) tick(1'b0, 16'h0000, 1'b0, 1'b0, MAX, 1'b1, 1'b1, acc);
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1, 1'b1);
        idle(2, 1'b1);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
